// File: rtl/lite_pkg.sv
// rtl/lite_pkg.sv - shared register-file constants and types
package lite_pkg;
   localparam int REG_W = 8;
   localparam int REG_N = 4;
   localparam logic [REG_W-1:0] RESET_VAL = 8'h00;
   typedef logic [1:0] reg_sel_t;
endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register load busy tracking, hazard stall and sticky load error
module reg_scoreboard
   import lite_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en_i,
   input  reg_sel_t          wr_sel_i,
   input  logic              ld_issue_i,
   input  reg_sel_t          ld_sel_i,
   input  logic              ld_valid_i,
   input  reg_sel_t          ld_tag_i,
   output logic [REG_N-1:0]  busy_o,
   output logic              stall_o,
   output logic              wr_acc_o,
   output logic              ld_hit_o,
   output logic              ld_err_o
);

   logic [REG_N-1:0] busy_q, busy_d;
   logic             ld_err_q, ld_err_d;
   logic             stall;
   logic             issue_acc;

   // Hazard check uses registered busy only; a same-cycle return does not unblock a request.
   always_comb begin
      stall     = (wr_en_i & busy_q[wr_sel_i]) | (ld_issue_i & busy_q[ld_sel_i]);
      issue_acc = ld_issue_i & ~stall;
      wr_acc_o  = wr_en_i & ~stall;
      ld_hit_o  = ld_valid_i & busy_q[ld_tag_i];
   end

   // Next busy/error state: a return clears its tag, an accepted issue sets its target.
   // An accepted issue can never target a busy tag, so the two updates never collide.
   always_comb begin
      busy_d   = busy_q;
      ld_err_d = ld_err_q | (ld_valid_i & ~busy_q[ld_tag_i]);
      if (ld_hit_o) begin
         busy_d[ld_tag_i] = 1'b0;
      end
      if (issue_acc) begin
         busy_d[ld_sel_i] = 1'b1;
      end
   end

   // Scoreboard state; reset forgets every outstanding load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= '0;
         ld_err_q <= 1'b0;
      end else begin
         busy_q   <= busy_d;
         ld_err_q <= ld_err_d;
      end
   end

   assign busy_o   = busy_q;
   assign stall_o  = stall;
   assign ld_err_o = ld_err_q;

endmodule

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - four-entry architectural register file with ALU write-back and load returns
module reg_bank
   import lite_pkg::*;
#(
   parameter int                REG_W     = lite_pkg::REG_W,
   parameter logic [REG_W-1:0]  RESET_VAL = REG_W'(lite_pkg::RESET_VAL)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  reg_sel_t          wr_sel,
   input  logic [REG_W-1:0]  wr_data,
   input  logic              ld_issue,
   input  reg_sel_t          ld_sel,
   input  logic              ld_valid,
   input  reg_sel_t          ld_tag,
   input  logic [REG_W-1:0]  ld_data,
   output logic [REG_W-1:0]  r0,
   output logic [REG_W-1:0]  r1,
   output logic [REG_W-1:0]  r2,
   output logic [REG_W-1:0]  r3,
   output logic [REG_N-1:0]  busy,
   output logic              stall,
   output logic              ld_err
);

   logic [REG_W-1:0] regs_q [REG_N];
   logic [REG_W-1:0] regs_d [REG_N];
   logic             wr_acc;
   logic             ld_hit;

   reg_scoreboard u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    (wr_en),
      .wr_sel_i   (wr_sel),
      .ld_issue_i (ld_issue),
      .ld_sel_i   (ld_sel),
      .ld_valid_i (ld_valid),
      .ld_tag_i   (ld_tag),
      .busy_o     (busy),
      .stall_o    (stall),
      .wr_acc_o   (wr_acc),
      .ld_hit_o   (ld_hit),
      .ld_err_o   (ld_err)
   );

   // Next register contents; write-back and load return never hit the same register
   // because a write-back to a busy register is stalled.
   always_comb begin
      regs_d = regs_q;
      if (wr_acc) begin
         regs_d[wr_sel] = wr_data;
      end
      if (ld_hit) begin
         regs_d[ld_tag] = ld_data;
      end
   end

   // Data registers, loaded with RESET_VAL on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_N; i++) begin
            regs_q[i] <= RESET_VAL;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign r0 = regs_q[0];
   assign r1 = regs_q[1];
   assign r2 = regs_q[2];
   assign r3 = regs_q[3];

endmodule
